// File: rtl/p_seq_acc.sv
// p_seq_acc: frame-based streaming accumulator for the perceptron datapath.
// Sums LANES signed operands per beat into a guard-extended accumulator over
// a frame of up to MAXBEATS beats, then presents one saturated result with
// overflow/underflow flags until the consumer takes it.

package p_seq_acc_pkg;
    typedef enum logic [1:0] {
        DT_BOOL = 2'd0,
        DT_INT  = 2'd1,
        DT_FXP  = 2'd2,
        DT_FP   = 2'd3
    } dtype_e;

    typedef struct packed {
        dtype_e      dtype;
        logic [15:0] prec;
    } dconf_t;
endpackage

`ifndef DEF_DCONF
`define DEF_DCONF '{dtype: p_seq_acc_pkg::DT_INT, prec: 16'd8}
`endif

module p_seq_acc
    import p_seq_acc_pkg::*;
#(
    parameter int     LANES    = 8,
    parameter int     MAXBEATS = 16,
    parameter dconf_t CONF     = `DEF_DCONF,
    localparam int    P        = int'(CONF.prec),
    localparam int    BW       = $clog2(MAXBEATS + 1)
) (
    input  logic                    clk,
    input  logic                    reset_,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic [LANES-1:0][P-1:0] in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [P-1:0]            out,
    output logic                    ovf,
    output logic                    udf,
    output logic                    forced,
    output logic [BW-1:0]           beats
);

    // Guard bits cover LANES*MAXBEATS most-extreme operands, so acc never wraps.
    localparam int GUARD = $clog2(LANES * MAXBEATS);
    localparam int AW    = P + GUARD;
    localparam logic [BW-1:0] CNT_LAST = BW'(MAXBEATS - 1);

    // Only integer-like data types make sense for a plain adder tree.
    if (!(CONF.dtype == DT_INT || CONF.dtype == DT_FXP)) begin : g_bad_dtype
        $error("p_seq_acc: CONF.dtype must be INT or FXP");
    end

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [BW-1:0]        cnt_q, cnt_d;
    logic [P-1:0]         out_q, out_d;
    logic                 ovf_q, ovf_d;
    logic                 udf_q, udf_d;
    logic                 forced_q, forced_d;
    logic [BW-1:0]        beats_q, beats_d;

    logic signed [AW-1:0] lane_sum;
    logic signed [AW-1:0] acc_sum;

    // Clip a full-width sum to P bits; returns {ovf, udf, value}.
    function automatic logic [P+1:0] saturate(input logic signed [AW-1:0] s);
        logic signed [AW-1:0] smax;
        logic signed [AW-1:0] smin;
        smax = AW'($signed({1'b0, {(P-1){1'b1}}}));
        smin = AW'($signed({1'b1, {(P-1){1'b0}}}));
        if (s > smax) begin
            return {1'b1, 1'b0, 1'b0, {(P-1){1'b1}}};
        end else if (s < smin) begin
            return {1'b0, 1'b1, 1'b1, {(P-1){1'b0}}};
        end
        return {1'b0, 1'b0, s[P-1:0]};
    endfunction

    // Sign-extend every lane to AW bits and add them up for the current beat.
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + AW'($signed(in[i]));
        end
        acc_sum = acc_q + lane_sum;
    end

    // Next-state and handshake logic for the ACC/HOLD controller.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        ovf_d     = ovf_q;
        udf_d     = udf_q;
        forced_d  = forced_q;
        beats_d   = beats_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ACC: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + BW'(1);
                    if (in_last || cnt_q == CNT_LAST) begin
                        state_d                = HOLD;
                        {ovf_d, udf_d, out_d}  = saturate(acc_sum);
                        forced_d               = ~in_last;
                        beats_d                = cnt_q + BW'(1);
                    end
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ACC;
                end
            end
            default: begin
                state_d = ACC;
            end
        endcase
    end

    // State, accumulator and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            state_q  <= ACC;
            acc_q    <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            forced_q <= 1'b0;
            beats_q  <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            forced_q <= forced_d;
            beats_q  <= beats_d;
        end
    end

    assign out    = out_q;
    assign ovf    = ovf_q;
    assign udf    = udf_q;
    assign forced = forced_q;
    assign beats  = beats_q;

endmodule

// File: tb/tb_p_seq_acc.sv
// Testbench for p_seq_acc with P=8, LANES=4, MAXBEATS=4.
// Expected frame results are queued as beats are driven and compared when
// the block presents them.

module tb_p_seq_acc;

    typedef struct packed {
        logic [7:0] out;
        logic       ovf;
        logic       udf;
        logic       forced;
        logic [2:0] beats;
    } res_t;

    logic            clk;
    logic            reset_;
    logic            in_valid;
    logic            in_ready;
    logic            in_last;
    logic [3:0][7:0] din;
    logic            out_valid;
    logic            out_ready;
    logic [7:0]      out;
    logic            ovf;
    logic            udf;
    logic            forced;
    logic [2:0]      beats;

    int   vectors;
    int   miscompares;
    res_t exp_q[$];
    int   m_sum;
    int   m_cnt;

    p_seq_acc #(
        .LANES    (4),
        .MAXBEATS (4),
        .CONF     (p_seq_acc_pkg::dconf_t'{dtype: p_seq_acc_pkg::DT_INT, prec: 16'd8})
    ) dut (
        .clk       (clk),
        .reset_    (reset_),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in        (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .ovf       (ovf),
        .udf       (udf),
        .forced    (forced),
        .beats     (beats)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: accumulate driven beats, push the expected result at frame end.
    function automatic void model_beat(input int a, input int b, input int c, input int d,
                                       input bit last);
        res_t e;
        m_sum = m_sum + a + b + c + d;
        m_cnt = m_cnt + 1;
        if (last || m_cnt == 4) begin
            e = '0;
            if (m_sum > 127) begin
                e.out = 8'd127;
                e.ovf = 1'b1;
            end else if (m_sum < -128) begin
                e.out = 8'h80;
                e.udf = 1'b1;
            end else begin
                e.out = 8'(m_sum);
            end
            e.forced = !last;
            e.beats  = 3'(m_cnt);
            exp_q.push_back(e);
            m_sum = 0;
            m_cnt = 0;
        end
    endfunction

    // Drive one beat at a falling edge; it is accepted on the following rising edge.
    task automatic beat(input int a, input int b, input int c, input int d, input bit last);
        din[0]   = 8'(a);
        din[1]   = 8'(b);
        din[2]   = 8'(c);
        din[3]   = 8'(d);
        in_valid = 1'b1;
        in_last  = last;
        model_beat(a, b, c, d, last);
        @(negedge clk);
    endtask

    // Wait (bounded) for out_valid and capture the presented result.
    task automatic take_result(output bit got, output res_t r);
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (out_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        r = {out, ovf, udf, forced, beats};
    endtask

    task automatic test_reset();
        reset_    = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        din       = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({out_valid, out, ovf, udf, forced, beats} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0", {out_valid, out, ovf, udf, forced, beats});
        end
        reset_ = 1'b1;
        @(negedge clk);
        vectors++;
        if ({in_ready, out_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_ready: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        bit   got;
        res_t obs;
        res_t e;
        out_ready = 1'b1;
        beat(1, 2, 3, 4, 1'b0);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_midframe_valid: got %b want 0", out_valid);
        end
        beat(1, 1, 1, 1, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_latency: out_valid got %b want 1", out_valid);
        end
        take_result(got, obs);
        vectors++;
        if (!got || exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL basic_result: no result presented");
        end else begin
            e = exp_q.pop_front();
            if (obs !== e) begin
                miscompares++;
                $display("FAIL basic_result: got %p want %p", obs, e);
            end
        end
        @(negedge clk);
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL basic_release: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_forced();
        bit   got;
        res_t obs;
        res_t e;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) beat(127, 127, 127, 127, 1'b0);
        in_valid = 1'b0;
        take_result(got, obs);
        vectors++;
        if (!got || exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL forced_result: no result presented");
        end else begin
            e = exp_q.pop_front();
            if (obs !== e) begin
                miscompares++;
                $display("FAIL forced_result: got %p want %p", obs, e);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_udf();
        bit   got;
        res_t obs;
        res_t e;
        out_ready = 1'b1;
        beat(-128, -128, -128, -128, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        take_result(got, obs);
        vectors++;
        if (!got || exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL udf_result: no result presented");
        end else begin
            e = exp_q.pop_front();
            if (obs !== e) begin
                miscompares++;
                $display("FAIL udf_result: got %p want %p", obs, e);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_cancel();
        bit   got;
        res_t obs;
        res_t e;
        out_ready = 1'b1;
        beat(100, 100, 0, 0, 1'b0);
        // A last flag without valid must not close the frame.
        in_valid = 1'b0;
        in_last  = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL cancel_invalid_last: out_valid got %b want 0", out_valid);
        end
        beat(-100, -100, -5, 0, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        take_result(got, obs);
        vectors++;
        if (!got || exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL cancel_result: no result presented");
        end else begin
            e = exp_q.pop_front();
            if (obs !== e) begin
                miscompares++;
                $display("FAIL cancel_result: got %p want %p", obs, e);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit   got;
        res_t obs;
        res_t first;
        res_t e;
        out_ready = 1'b0;
        beat(5, 0, 0, 0, 1'b1);
        // Next frame's beat waits on the input while the result is held.
        din      = '0;
        din[0]   = 8'd7;
        in_valid = 1'b1;
        in_last  = 1'b1;
        take_result(got, first);
        vectors++;
        if (!got || exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL bp_result: no result presented");
        end else begin
            e = exp_q.pop_front();
            if (first !== e) begin
                miscompares++;
                $display("FAIL bp_result: got %p want %p", first, e);
            end
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            obs = {out, ovf, udf, forced, beats};
            vectors++;
            if ({in_ready, out_valid} !== 2'b01 || obs !== first) begin
                miscompares++;
                $display("FAIL bp_hold: got in_ready=%b out_valid=%b res=%p want 0 1 %p",
                         in_ready, out_valid, obs, first);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if ({in_ready, out_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL bp_handoff: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        model_beat(7, 0, 0, 0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        take_result(got, obs);
        vectors++;
        if (!got || exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL bp_next_frame: no result presented");
        end else begin
            e = exp_q.pop_front();
            if (obs !== e) begin
                miscompares++;
                $display("FAIL bp_next_frame: got %p want %p", obs, e);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        bit   got;
        res_t obs;
        res_t e;
        out_ready = 1'b1;
        beat(9, 9, 9, 9, 1'b0);
        beat(1, 1, 1, 1, 1'b0);
        in_valid = 1'b0;
        m_sum    = 0;
        m_cnt    = 0;
        reset_   = 1'b0;
        @(negedge clk);
        vectors++;
        if ({out_valid, out, ovf, udf, forced, beats} !== 15'd0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got %h want 0", {out_valid, out, ovf, udf, forced, beats});
        end
        reset_ = 1'b1;
        @(negedge clk);
        beat(1, 0, 0, 0, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        take_result(got, obs);
        vectors++;
        if (!got || exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL midreset_result: no result presented");
        end else begin
            e = exp_q.pop_front();
            if (obs !== e) begin
                miscompares++;
                $display("FAIL midreset_result: got %p want %p", obs, e);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_sum       = 0;
        m_cnt       = 0;
        reset_      = 1'b0;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        din         = '0;
        out_ready   = 1'b0;
        test_reset();
        test_basic();
        test_forced();
        test_udf();
        test_cancel();
        test_back_to_back();
        test_reset_midframe();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d results outstanding, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
